// File: rtl/rr_arbiter_param.sv
// rr_arbiter_param
//   N-way round-robin arbiter with bus-lock semantics and optional max-hold
//   preemption. A requester that wins keeps the grant for as long as it keeps
//   requesting. The only exception is when MAX_HOLD is non-zero, the tenure
//   has lasted MAX_HOLD cycles, and another requester is waiting. All outputs
//   are registered, so there is no combinational path from req to gnt.
//
// Handshake: req is a level with no handshake. A requester owns the resource
//   in every cycle where its gnt bit is high. Dropping req releases the grant
//   at the next edge.
//
// Ports
//   clk        in   1      clock, posedge
//   rst        in   1      synchronous active-high reset
//   req        in   N      request vector, bit i = requester i
//   gnt        out  N      registered one-hot grant, zero when idle
//   gnt_idx    out  IDX_W  encoded owner; keeps the last owner while idle
//   gnt_valid  out  1      high while a grant is held; also the FSM state (OWNED)
//   gnt_new    out  1      one-cycle pulse in the first cycle of each tenure
module rr_arbiter_param #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid,
  output logic                 gnt_new
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   ptr_q, ptr_n;
  logic [CNT_W-1:0]   hold_q, hold_n;
  logic [N-1:0]       gnt_n;
  logic [IDX_W-1:0]   idx_n;
  logic               new_n;

  // Candidate set for this edge and the pointer-ordered winner among it.
  logic               do_grant;
  logic [N-1:0]       cand;
  logic [IDX_W:0]     pk;
  logic [N-1:0]       owner_oh;
  logic [N-1:0]       others;

  // Returns {found, index} of the first set bit of r in the order
  // p, p+1, ..., N-1, 0, ..., p-1. Rotating a doubled copy puts requester p
  // at bit 0, so the scan below is a plain lowest-set-bit search.
  function automatic logic [IDX_W:0] pick(input logic [N-1:0] r,
                                          input logic [IDX_W-1:0] p);
    logic [2*N-1:0] dbl;
    logic [IDX_W:0] sum;
    logic           found;
    logic [IDX_W-1:0] w;
    dbl   = {r, r} >> p;
    sum   = '0;
    found = 1'b0;
    w     = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && dbl[k]) begin
        found = 1'b1;
        sum   = {1'b0, p} + (IDX_W+1)'(k);
        if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
        w     = sum[IDX_W-1:0];
      end
    end
    return {found, w};
  endfunction

  assign owner_oh  = N'(1) << gnt_idx;
  assign others    = req & ~owner_oh;
  assign gnt_valid = (state_q == OWNED);

  always_comb begin
    state_n  = state_q;
    gnt_n    = gnt;
    idx_n    = gnt_idx;
    new_n    = 1'b0;
    ptr_n    = ptr_q;
    hold_n   = hold_q;
    do_grant = 1'b0;
    cand     = '0;
    pk       = '0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          do_grant = 1'b1;
          cand     = req;
        end
      end
      OWNED: begin
        if ((req & owner_oh) == '0) begin
          // Release. Re-arbitrate in the same edge so there is no idle gap.
          // ptr already points past the owner, so it can only win again
          // when it is the sole requester.
          if (|req) begin
            do_grant = 1'b1;
            cand     = req;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            hold_n  = '0;
          end
        end else if ((MAX_HOLD != 0) && (hold_q == HOLD_MAX) && (|others)) begin
          // Tenure limit reached and someone is waiting: preempt.
          do_grant = 1'b1;
          cand     = others;
        end else begin
          // Hold. The counter saturates at the limit, so an uncontested
          // owner keeps the grant and is preempted by the first competitor.
          if (MAX_HOLD == 0) begin
            hold_n = '0;
          end else if (hold_q != HOLD_MAX) begin
            hold_n = hold_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase

    pk = pick(cand, ptr_q);
    if (do_grant && pk[IDX_W]) begin
      state_n = OWNED;
      gnt_n   = N'(1) << pk[IDX_W-1:0];
      idx_n   = pk[IDX_W-1:0];
      new_n   = 1'b1;
      ptr_n   = (pk[IDX_W-1:0] == IDX_W'(N-1)) ? '0 : pk[IDX_W-1:0] + IDX_W'(1);
      hold_n  = (MAX_HOLD == 0) ? '0 : CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_new <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_n;
      gnt     <= gnt_n;
      gnt_idx <= idx_n;
      gnt_new <= new_n;
      ptr_q   <= ptr_n;
      hold_q  <= hold_n;
    end
  end

endmodule
